// File: rtl/cluster_iso_pkg.sv
// Shared types and helpers for the cluster input isolation clamp.
package cluster_iso_pkg;

    typedef enum logic [2:0] {
        RELEASED   = 3'd0,
        ISO_SETTLE = 3'd1,
        CLAMPED    = 3'd2,
        REL_WAIT   = 3'd3,
        REL_SETTLE = 3'd4
    } iso_state_e;

    // A zero settle time still needs a one-bit counter to keep widths legal.
    function automatic int cnt_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/cluster_iso_clamp_bit.sv
// One bit of the clamp data path; swap for a hardened isolation cell here.
module cluster_iso_clamp_bit (
    input  logic clamp_i,
    input  logic data_i,
    input  logic clamp_val_i,
    output logic data_o
);

    assign data_o = clamp_i ? clamp_val_i : data_i;

endmodule

// File: rtl/cluster_iso_clamp_ctrl.sv
// Sequences isolation of a WIDTH-bit cluster input crossing and clamps the bus.
// Optional build macro: CLUSTER_ISO_HOLD_LAST_EN (clamp to the last released value).
module cluster_iso_clamp_ctrl
    import cluster_iso_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] CLAMP_VALUE   = '0,
    parameter int               SETTLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             iso_req_i,
    input  logic             pwr_ok_i,
    output logic             iso_ack_o,
    output logic             clamp_o,
    output logic             busy_o,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic [2:0]       state_o
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_RELEASED   = RELEASED;
    localparam logic [2:0] S_ISO_SETTLE = ISO_SETTLE;
    localparam logic [2:0] S_CLAMPED    = CLAMPED;
    localparam logic [2:0] S_REL_WAIT   = REL_WAIT;
    localparam logic [2:0] S_REL_SETTLE = REL_SETTLE;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clamp_q, clamp_d;
    logic             ack_q, ack_d;
    logic [WIDTH-1:0] clamp_src;

    // Level handshake: iso_req_i is held by the requester; iso_ack_o follows it
    // only once the clamp has settled, and ack high always implies clamp high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clamp_d = clamp_q;
        ack_d   = ack_q;
        case (state_q)
            S_RELEASED: begin
                if (iso_req_i || !pwr_ok_i) begin
                    clamp_d = 1'b1;
                    cnt_d   = '0;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = S_CLAMPED;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = S_ISO_SETTLE;
                    end
                end
            end
            S_ISO_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CLAMPED;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLAMPED: begin
                if (!iso_req_i) state_d = S_REL_WAIT;
            end
            S_REL_WAIT: begin
                if (iso_req_i) begin
                    state_d = S_CLAMPED;
                end else if (pwr_ok_i) begin
                    cnt_d = '0;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = S_RELEASED;
                        clamp_d = 1'b0;
                        ack_d   = 1'b0;
                    end else begin
                        state_d = S_REL_SETTLE;
                    end
                end
            end
            S_REL_SETTLE: begin
                // Any doubt about the source domain aborts back to isolation.
                if (iso_req_i || !pwr_ok_i) begin
                    state_d = S_CLAMPED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RELEASED;
                    clamp_d = 1'b0;
                    ack_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_CLAMPED;
                clamp_d = 1'b1;
                ack_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_CLAMPED;
            cnt_q   <= '0;
            clamp_q <= 1'b1;
            ack_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clamp_q <= clamp_d;
            ack_q   <= ack_d;
        end
    end

`ifdef CLUSTER_ISO_HOLD_LAST_EN
    logic [WIDTH-1:0] hold_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= CLAMP_VALUE;
        end else if (state_q == S_RELEASED) begin
            hold_q <= in_i;
        end
    end

    assign clamp_src = hold_q;
`else
    assign clamp_src = CLAMP_VALUE;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cluster_iso_clamp_bit u_bit (
            .clamp_i     (clamp_q),
            .data_i      (in_i[i]),
            .clamp_val_i (clamp_src[i]),
            .data_o      (out_o[i])
        );
    end

    assign clamp_o   = clamp_q;
    assign iso_ack_o = ack_q;
    assign busy_o    = (state_q == S_ISO_SETTLE) || (state_q == S_REL_WAIT) ||
                       (state_q == S_REL_SETTLE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_cluster_iso_clamp_ctrl.sv
// Bench for cluster_iso_clamp_ctrl: SETTLE_CYCLES=4 (32 bit) and SETTLE_CYCLES=0 (8 bit) instances.
module tb_cluster_iso_clamp_ctrl;
    import cluster_iso_pkg::*;

    typedef struct {
        logic        rst;
        logic        req;
        logic        ok;
        logic [31:0] din;
        logic        clamp;
        logic        ack;
        logic        busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_a, ok_a, ack_a, clamp_a, busy_a;
    logic [31:0] in_a, out_a;
    logic [2:0]  st_a;
    logic        req_b, ok_b, ack_b, clamp_b, busy_b;
    logic [7:0]  in_b, out_b;
    logic [2:0]  st_b;

    vec_t        tab_a[$];
    vec_t        tab_b[$];
    logic [34:0] exp_q[$];
    logic [31:0] hold_m[2];
    logic        rel_m[2];
    int          tests_run;
    int          tests_failed;

    cluster_iso_clamp_ctrl #(.WIDTH(32), .CLAMP_VALUE(32'h0), .SETTLE_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .iso_req_i(req_a), .pwr_ok_i(ok_a),
        .iso_ack_o(ack_a), .clamp_o(clamp_a), .busy_o(busy_a),
        .in_i(in_a), .out_o(out_a), .state_o(st_a)
    );

    cluster_iso_clamp_ctrl #(.WIDTH(8), .CLAMP_VALUE(8'hA5), .SETTLE_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .iso_req_i(req_b), .pwr_ok_i(ok_b),
        .iso_ack_o(ack_b), .clamp_o(clamp_b), .busy_o(busy_b),
        .in_i(in_b), .out_o(out_b), .state_o(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input int sel, input logic r, input logic q, input logic k,
                                input logic [31:0] d, input logic c, input logic a,
                                input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.ok = k; v.din = d; v.clamp = c; v.ack = a; v.busy = b;
        if (sel == 0) tab_a.push_back(v);
        else          tab_b.push_back(v);
    endfunction

    function automatic void add_n(input int n, input int sel, input logic r, input logic q,
                                  input logic k, input logic [31:0] d, input logic c,
                                  input logic a, input logic b);
        for (int i = 0; i < n; i++) add(sel, r, q, k, d, c, a, b);
    endfunction

    task automatic run_vec(input int sel, input int idx, input vec_t v);
        logic [31:0] din, cval, out_exp;
        logic [34:0] got, exp;
        logic [2:0]  st_got;
        logic [2:0]  st_exp;
        din  = (sel == 0) ? v.din : {24'h0, v.din[7:0]};
        cval = (sel == 0) ? 32'h0 : 32'hA5;
        rst  = v.rst;
        if (sel == 0) begin
            req_a = v.req; ok_a = v.ok; in_a = din;
        end else begin
            req_b = v.req; ok_b = v.ok; in_b = din[7:0];
        end
        if (v.rst)           hold_m[sel] = cval;
        else if (rel_m[sel]) hold_m[sel] = din;
        rel_m[sel] = !v.rst && !v.clamp;
`ifdef CLUSTER_ISO_HOLD_LAST_EN
        out_exp = v.clamp ? hold_m[sel] : din;
`else
        out_exp = v.clamp ? cval : din;
`endif
        exp_q.push_back({v.clamp, v.ack, v.busy, out_exp});
        @(posedge clk);
        #1;
        got    = (sel == 0) ? {clamp_a, ack_a, busy_a, out_a}
                            : {clamp_b, ack_b, busy_b, 24'h0, out_b};
        st_got = (sel == 0) ? st_a : st_b;
        exp    = exp_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s row %0d: clamp/ack/busy/out got %b/%b/%b/%h expected %b/%b/%b/%h",
                     (sel == 0) ? "settle4" : "settle0", idx,
                     got[34], got[33], got[32], got[31:0], exp[34], exp[33], exp[32], exp[31:0]);
        end
        if (v.rst) begin
            st_exp = CLAMPED;
            tests_run++;
            if (st_got !== st_exp) begin
                tests_failed++;
                $display("FAIL %s reset_state row %0d: got %0d expected %0d",
                         (sel == 0) ? "settle4" : "settle0", idx, st_got, st_exp);
            end
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1;
        req_a = 1'b1; ok_a = 1'b0; in_a = 32'hDEADBEEF;
        req_b = 1'b1; ok_b = 1'b0; in_b = 8'h3C;
        hold_m[0] = 32'h0; hold_m[1] = 32'hA5;
        rel_m[0] = 1'b0; rel_m[1] = 1'b0;

        // SETTLE_CYCLES=4: reset, release, isolate, aborts, dropped request, emergency, reset.
        add(0, 1, 1, 0, 32'hDEADBEEF, 1, 1, 0);
        add(0, 0, 1, 1, 32'hDEADBEEF, 1, 1, 0);
        add(0, 0, 0, 1, 32'hDEADBEEF, 1, 1, 1);
        add_n(4, 0, 0, 0, 1, 32'hDEADBEEF, 1, 1, 1);
        add(0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0);
        add(0, 0, 0, 1, $urandom, 0, 0, 0);
        add(0, 0, 0, 1, $urandom, 0, 0, 0);
        add(0, 0, 1, 1, 32'hCAFEF00D, 1, 0, 1);
        add_n(3, 0, 0, 1, 1, 32'hCAFEF00D, 1, 0, 1);
        add(0, 0, 1, 1, 32'hCAFEF00D, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 0, 0, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 0, 1, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 0, 1, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 0, 0, 32'h0BADF00D, 1, 1, 0);
        add(0, 0, 0, 1, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 1, 1, 32'h0BADF00D, 1, 1, 0);
        add(0, 0, 0, 1, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 0, 1, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 1, 1, 32'h0BADF00D, 1, 1, 0);
        add(0, 0, 0, 1, 32'h0BADF00D, 1, 1, 1);
        add_n(4, 0, 0, 0, 1, 32'h0BADF00D, 1, 1, 1);
        add(0, 0, 0, 1, 32'h12345678, 0, 0, 0);
        add(0, 0, 1, 1, 32'h12345678, 1, 0, 1);
        add_n(3, 0, 0, 0, 1, 32'h00000000, 1, 0, 1);
        add(0, 0, 0, 1, 32'h00000000, 1, 1, 0);
        add(0, 0, 0, 1, 32'h00000000, 1, 1, 1);
        add_n(4, 0, 0, 0, 1, 32'hA5A5A5A5, 1, 1, 1);
        add(0, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 0);
        add(0, 0, 0, 0, 32'h11111111, 1, 0, 1);
        add_n(3, 0, 0, 1, 1, 32'h00000000, 1, 0, 1);
        add(0, 0, 1, 1, 32'h00000000, 1, 1, 0);
        add(0, 0, 0, 1, 32'h00000000, 1, 1, 1);
        add(0, 0, 0, 1, 32'h00000000, 1, 1, 1);
        add(0, 1, 0, 1, 32'h00000000, 1, 1, 0);
        add(0, 0, 0, 1, 32'h00000000, 1, 1, 1);

        // SETTLE_CYCLES=0: ack and clamp move on the edge that samples the request.
        add(1, 1, 1, 0, 32'h3C, 1, 1, 0);
        add(1, 0, 0, 1, 32'h3C, 1, 1, 1);
        add(1, 0, 0, 1, 32'h3C, 0, 0, 0);
        add(1, 0, 0, 1, 32'(8'($urandom_range(0, 255))), 0, 0, 0);
        add(1, 0, 1, 1, 32'h5A, 1, 1, 0);
        add(1, 0, 0, 0, 32'h5A, 1, 1, 1);
        add(1, 0, 0, 1, 32'hC3, 0, 0, 0);
        add(1, 0, 0, 0, 32'h77, 1, 1, 0);
        add(1, 0, 0, 0, 32'h77, 1, 1, 1);

        for (int i = 0; i < tab_a.size(); i++) run_vec(0, i, tab_a[i]);
        for (int i = 0; i < tab_b.size(); i++) run_vec(1, i, tab_b[i]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cluster_iso_clamp_ctrl.md
Name: cluster_iso_clamp_ctrl

Overview:
- Parametrised, multi-bit successor of the single-bit input clamp, for power-domain crossings into the cluster.
- Sequences isolation with a level request/acknowledge handshake and a programmable settle time.
- Forces a WIDTH-bit bus to a clamp value while isolated.
- Sits on the always-on side of every cluster input crossing; driven by the cluster power controller.

Parameters:
- WIDTH, 32, number of clamped data bits (>=1).
- CLAMP_VALUE, '0, WIDTH-bit value driven while clamped.
- SETTLE_CYCLES, 4, cycles between clamp change and ack change (>=0).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- iso_req_i  in  1  level request: 1 = isolate, 0 = release.
- pwr_ok_i  in  1  source domain powered and stable.
- iso_ack_o  out  1  1 = isolation complete (clamp settled).
- clamp_o  out  1  registered clamp state; exported for monitoring.
- busy_o  out  1  settle in progress.
- in_i  in  WIDTH  data from the switchable domain.
- out_o  out  WIDTH  clamp_o ? CLAMP_VALUE : in_i (combinational data path).

Behaviour:
- FSM states: RELEASED, ISO_SETTLE, CLAMPED, REL_WAIT, REL_SETTLE. Counter cnt_q width $clog2(SETTLE_CYCLES+1), minimum 1.
- Reset: state CLAMPED, clamp_o=1, iso_ack_o=1, busy_o=0, cnt_q=0. Safe default: domain isolated.
- RELEASED, iso_req_i=1: next state ISO_SETTLE, clamp_o=1 next cycle, cnt_q=0. If SETTLE_CYCLES==0, go directly to CLAMPED with iso_ack_o=1 on the same edge.
- ISO_SETTLE:
  - cnt_q increments each cycle.
  - When cnt_q==SETTLE_CYCLES-1, go to CLAMPED; iso_ack_o=1 from the next cycle.
  - Dropping iso_req_i here does not abort; isolation completes first.
  - Ack rises exactly SETTLE_CYCLES+1 cycles after the request edge is sampled.
- CLAMPED, iso_req_i=0: go to REL_WAIT. clamp_o and iso_ack_o stay 1.
- REL_WAIT:
  - Stays until pwr_ok_i=1, then REL_SETTLE with cnt_q=0.
  - If iso_req_i returns to 1, go back to CLAMPED.
- REL_SETTLE:
  - Counts SETTLE_CYCLES with clamp still asserted, then RELEASED: clamp_o=0 and iso_ack_o=0 on the same edge.
  - iso_req_i=1 or pwr_ok_i=0 during REL_SETTLE aborts to CLAMPED. Clamp never drops.
  - SETTLE_CYCLES==0: REL_WAIT goes straight to RELEASED.
- RELEASED, pwr_ok_i=0 with iso_req_i=0: emergency isolate. Same path as a request (ISO_SETTLE).
- busy_o=1 in ISO_SETTLE, REL_WAIT and REL_SETTLE only.
- Invariant: iso_ack_o=1 implies clamp_o=1. clamp_o only drops on the transition into RELEASED.
- Reset asserted mid-operation returns to CLAMPED in one cycle, regardless of state.
- out_o has zero latency relative to in_i. No register on the data path.

Optional Feature:
- Macro: CLUSTER_ISO_HOLD_LAST_EN.
- Defined:
  - A WIDTH-bit hold register captures in_i every cycle while in RELEASED.
  - While clamp_o=1, out_o drives the held value instead of CLAMP_VALUE.
  - The hold register resets to CLAMP_VALUE.
- Undefined: no hold register; out_o drives CLAMP_VALUE while clamped.

Decomposition:
- Package cluster_iso_pkg:
  - iso_state_e enum covering the five states.
  - Localparam helper for the counter width.
- One sub-module, cluster_iso_clamp_bit: WIDTH-replicated combinational mux per bit, with hardened-cell replacement point.
- FSM and counter live in the top module.

Test Plan:
1. Reset with WIDTH=32, SETTLE_CYCLES=4, in_i=0xDEADBEEF -> out_o=0, clamp_o=1, iso_ack_o=1 on the first post-reset cycle.
2. Release: iso_req_i=0, pwr_ok_i=1 -> busy_o for 5 cycles (REL_WAIT + 4 settle); then clamp_o=0, ack=0, out_o=0xDEADBEEF.
3. Isolate from RELEASED: iso_req_i=1 -> clamp_o=1 next cycle, out_o=0, iso_ack_o=1 exactly 5 cycles after the request sample.
4. Abort: drop pwr_ok_i on the 2nd REL_SETTLE cycle -> back to CLAMPED, clamp_o never 0. Dropping iso_req_i during ISO_SETTLE still yields ack.
5. SETTLE_CYCLES=0 -> ack and clamp toggle on the cycle after the request. Emergency pwr_ok_i=0 in RELEASED -> clamp next cycle.
6. CLUSTER_ISO_HOLD_LAST_EN defined, in_i=0x12345678 then isolate and change in_i to 0 -> out_o holds 0x12345678 while clamped.
